// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the two-port memory bus arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int WAIT_CW = 4;

    typedef logic [WAIT_CW-1:0] wait_cnt_t;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational two-way round-robin picker
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    always_comb begin
        o_grant_valid = |i_req;
        o_grant_id    = PORT0;
        // On a tie the port that did not win last time goes first.
        if (i_req == 2'b11) begin
            o_grant_id = ~i_last_grant;
        end else if (i_req[1]) begin
            o_grant_id = PORT1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one external memory port between two requesters
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic          MAIN_CLK,
    input  logic          MAIN_RST,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] ADDR0,
    input  logic [DW-1:0] WDATA0,
    output logic          ACK0,
    output logic [DW-1:0] RDATA0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK1,
    output logic [DW-1:0] RDATA1,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          MEM_RD,
    output logic          MEM_WR
);

    localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(WAIT_STATES);

    arb_state_t    r_state;
    logic          r_last_grant;
    logic          r_gid;
    logic          r_we;
    wait_cnt_t     r_cnt;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_rd;
    logic          r_mem_wr;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_grant_valid;
    logic          w_grant_id;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    arb_rr_pick u_pick (
        .i_req         ({REQ1, REQ0}),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_we    = (w_grant_id == PORT1) ? WE1    : WE0;
    assign w_addr  = (w_grant_id == PORT1) ? ADDR1  : ADDR0;
    assign w_wdata = (w_grant_id == PORT1) ? WDATA1 : WDATA0;

    always_ff @(posedge MAIN_CLK or negedge MAIN_RST) begin
        if (!MAIN_RST) begin
            r_state      <= IDLE;
            r_last_grant <= PORT1;
            r_gid        <= PORT0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_gid        <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_we         <= w_we;
                        r_cnt        <= WAIT_LOAD;
                        r_mem_addr   <= w_addr;
                        r_mem_wdata  <= w_wdata;
                        r_mem_rd     <= ~w_we;
                        r_mem_wr     <= w_we;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Last strobe cycle: memory data is sampled on this edge.
                    if (r_cnt == '0) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (!r_we) begin
                            if (r_gid == PORT1) begin
                                r_rdata1 <= MEM_RDATA;
                            end else begin
                                r_rdata0 <= MEM_RDATA;
                            end
                        end
                        r_ack0  <= (r_gid == PORT0);
                        r_ack1  <= (r_gid == PORT1);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign MEM_RD    = r_mem_rd;
    assign MEM_WR    = r_mem_wr;
    assign ACK0      = r_ack0;
    assign ACK1      = r_ack1;
    assign RDATA0    = r_rdata0;
    assign RDATA1    = r_rdata1;

endmodule
